// File: rtl/writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | writeback: final pipeline stage. RF write/bypass register, SREG write   |
// | FIFO with valid/ready drain, back-pressure and retire counter.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

package core;
  localparam int REG_WIDTH     = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int ADDR_WIDTH    = 30;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           insn;
  } InsnBundle;
endpackage

module writeback #(
  parameter int REG_WIDTH     = core::REG_WIDTH,
  parameter int RF_ADDR_WIDTH = core::RF_ADDR_WIDTH,
  parameter int SQ_DEPTH      = 4,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  core::InsnBundle             insn,
  input  logic                        ex_rf_wr_en,
  input  logic [RF_ADDR_WIDTH-1:0]    ex_rf_wr_addr,
  input  logic [REG_WIDTH-1:0]        ex_rf_wr_val,
  input  logic                        ex_sreg_wr_en,
  input  logic [4:0]                  ex_sreg_wr_group,
  input  logic [2:0]                  ex_sreg_wr_regnum,
  input  logic [1:0]                  ex_sreg_wr_plevel,
  input  logic [REG_WIDTH-1:0]        ex_sreg_wr_val,
  output logic                        rf_we,
  output logic [RF_ADDR_WIDTH-1:0]    rf_waddr,
  output logic [REG_WIDTH-1:0]        rf_wdata,
  output logic                        sreg_req_valid,
  input  logic                        sreg_req_ready,
  output logic [4:0]                  sreg_req_group,
  output logic [2:0]                  sreg_req_regnum,
  output logic [1:0]                  sreg_req_plevel,
  output logic [REG_WIDTH-1:0]        sreg_req_val,
  output logic                        sreg_pending,
  output logic                        wb_stall,
  output logic                        sq_overflow,
  output logic                        retire_valid,
  output logic [core::ADDR_WIDTH-1:0] retire_addr,
  output logic [CNT_WIDTH-1:0]        retired_count
);

  localparam int c_PTR_W   = $clog2(SQ_DEPTH);
  localparam int c_CNT_W   = c_PTR_W + 1;
  localparam int c_ENTRY_W = 10 + REG_WIDTH;
  localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(SQ_DEPTH);
  localparam logic [c_CNT_W-1:0] c_STALL_LVL = c_CNT_W'(SQ_DEPTH - 1);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST  = c_PTR_W'(SQ_DEPTH - 1);

  logic                         r_rf_we;
  logic [RF_ADDR_WIDTH-1:0]     r_rf_waddr;
  logic [REG_WIDTH-1:0]         r_rf_wdata;
  logic                         r_retire_valid;
  logic [core::ADDR_WIDTH-1:0]  r_retire_addr;
  logic [CNT_WIDTH-1:0]         r_retired_count;

  logic [c_ENTRY_W-1:0]         r_mem [SQ_DEPTH];
  logic [c_PTR_W-1:0]           r_wr_ptr;
  logic [c_PTR_W-1:0]           r_rd_ptr;
  logic [c_CNT_W-1:0]           r_count;
  logic                         r_overflow;

  logic                         w_sq_empty;
  logic                         w_sq_full;
  logic                         w_pop;
  logic                         w_push;
  logic                         w_drop;
  logic [c_ENTRY_W-1:0]         w_entry;
  logic [c_ENTRY_W-1:0]         w_head;
  logic [c_PTR_W-1:0]           w_wr_ptr_nxt;
  logic [c_PTR_W-1:0]           w_rd_ptr_nxt;
  logic                         w_unused;

  // The raw instruction word is carried for debug upstream only.
  assign w_unused = ^insn.insn;

  // RF write port; address/data hold when idle so the bypass source stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= ex_rf_wr_en;
      if (ex_rf_wr_en) begin
        r_rf_waddr <= ex_rf_wr_addr;
        r_rf_wdata <= ex_rf_wr_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_valid  <= 1'b0;
      r_retire_addr   <= '0;
      r_retired_count <= '0;
    end else begin
      r_retire_valid <= insn.valid;
      r_retire_addr  <= insn.addr;
      if (insn.valid) begin
        r_retired_count <= r_retired_count + CNT_WIDTH'(1);
      end
    end
  end

  assign w_sq_empty   = (r_count == '0);
  assign w_sq_full    = (r_count == c_FULL);
  assign w_pop        = !w_sq_empty && sreg_req_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push       = ex_sreg_wr_en && (!w_sq_full || w_pop);
  assign w_drop       = ex_sreg_wr_en && !w_push;
  assign w_entry      = {ex_sreg_wr_group, ex_sreg_wr_regnum, ex_sreg_wr_plevel, ex_sreg_wr_val};
  assign w_wr_ptr_nxt = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= w_wr_ptr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign w_head          = r_mem[r_rd_ptr];
  assign sreg_req_group  = w_head[REG_WIDTH+9 -: 5];
  assign sreg_req_regnum = w_head[REG_WIDTH+4 -: 3];
  assign sreg_req_plevel = w_head[REG_WIDTH+1 -: 2];
  assign sreg_req_val    = w_head[REG_WIDTH-1:0];
  assign sreg_req_valid  = !w_sq_empty;
  assign sreg_pending    = !w_sq_empty;
  // Stall one entry early: execute may already have a write in flight.
  assign wb_stall        = (r_count >= c_STALL_LVL);
  assign sq_overflow     = r_overflow;

  assign rf_we         = r_rf_we;
  assign rf_waddr      = r_rf_waddr;
  assign rf_wdata      = r_rf_wdata;
  assign retire_valid  = r_retire_valid;
  assign retire_addr   = r_retire_addr;
  assign retired_count = r_retired_count;

endmodule

`default_nettype wire

// File: tb/tb_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_writeback: directed self-checking bench for writeback.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_writeback;

  localparam int c_RW  = 32;
  localparam int c_AW  = 5;
  localparam int c_CW  = 4;

  logic                        clk;
  logic                        rst_n;
  core::InsnBundle             insn;
  logic                        ex_rf_wr_en;
  logic [c_AW-1:0]             ex_rf_wr_addr;
  logic [c_RW-1:0]             ex_rf_wr_val;
  logic                        ex_sreg_wr_en;
  logic [4:0]                  ex_sreg_wr_group;
  logic [2:0]                  ex_sreg_wr_regnum;
  logic [1:0]                  ex_sreg_wr_plevel;
  logic [c_RW-1:0]             ex_sreg_wr_val;
  logic                        rf_we;
  logic [c_AW-1:0]             rf_waddr;
  logic [c_RW-1:0]             rf_wdata;
  logic                        sreg_req_valid;
  logic                        sreg_req_ready;
  logic [4:0]                  sreg_req_group;
  logic [2:0]                  sreg_req_regnum;
  logic [1:0]                  sreg_req_plevel;
  logic [c_RW-1:0]             sreg_req_val;
  logic                        sreg_pending;
  logic                        wb_stall;
  logic                        sq_overflow;
  logic                        retire_valid;
  logic [core::ADDR_WIDTH-1:0] retire_addr;
  logic [c_CW-1:0]             retired_count;

  int checks = 0;
  int errors = 0;

  writeback #(
    .REG_WIDTH     (c_RW),
    .RF_ADDR_WIDTH (c_AW),
    .SQ_DEPTH      (4),
    .CNT_WIDTH     (c_CW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .insn              (insn),
    .ex_rf_wr_en       (ex_rf_wr_en),
    .ex_rf_wr_addr     (ex_rf_wr_addr),
    .ex_rf_wr_val      (ex_rf_wr_val),
    .ex_sreg_wr_en     (ex_sreg_wr_en),
    .ex_sreg_wr_group  (ex_sreg_wr_group),
    .ex_sreg_wr_regnum (ex_sreg_wr_regnum),
    .ex_sreg_wr_plevel (ex_sreg_wr_plevel),
    .ex_sreg_wr_val    (ex_sreg_wr_val),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .sreg_req_valid    (sreg_req_valid),
    .sreg_req_ready    (sreg_req_ready),
    .sreg_req_group    (sreg_req_group),
    .sreg_req_regnum   (sreg_req_regnum),
    .sreg_req_plevel   (sreg_req_plevel),
    .sreg_req_val      (sreg_req_val),
    .sreg_pending      (sreg_pending),
    .wb_stall          (wb_stall),
    .sq_overflow       (sq_overflow),
    .retire_valid      (retire_valid),
    .retire_addr       (retire_addr),
    .retired_count     (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic en, input logic [4:0] g, input logic [2:0] r,
                          input logic [1:0] p, input logic [31:0] v);
    ex_sreg_wr_en     = en;
    ex_sreg_wr_group  = g;
    ex_sreg_wr_regnum = r;
    ex_sreg_wr_plevel = p;
    ex_sreg_wr_val    = v;
  endtask

  initial begin
    rst_n          = 1'b0;
    insn           = '0;
    ex_rf_wr_en    = 1'b0;
    ex_rf_wr_addr  = '0;
    ex_rf_wr_val   = '0;
    sreg_req_ready = 1'b0;
    set_push(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);

    // Reset state
    #2;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_valid", sreg_req_valid, 0);
    chk("rst_stall", wb_stall, 0);
    chk("rst_ovf", sq_overflow, 0);
    chk("rst_count", retired_count, 0);
    step();
    rst_n = 1'b1;

    // RF path
    ex_rf_wr_en = 1'b1; ex_rf_wr_addr = 5'd5; ex_rf_wr_val = 32'hDEAD_BEEF;
    step();
    chk("rf_we1", rf_we, 1);
    chk("rf_waddr1", rf_waddr, 5);
    chk("rf_wdata1", rf_wdata, 32'hDEAD_BEEF);
    ex_rf_wr_en = 1'b0; ex_rf_wr_addr = 5'd9; ex_rf_wr_val = 32'h0;
    step();
    chk("rf_we2", rf_we, 0);
    chk("rf_waddr_hold", rf_waddr, 5);
    chk("rf_wdata_hold", rf_wdata, 32'hDEAD_BEEF);

    // SREG drain order with ready held high
    sreg_req_ready = 1'b1;
    set_push(1'b1, 5'd10, 3'd7, 2'd0, 32'h1);
    step();
    chk("d1_valid", sreg_req_valid, 1);
    chk("d1_group", sreg_req_group, 10);
    chk("d1_regnum", sreg_req_regnum, 7);
    chk("d1_val", sreg_req_val, 32'h1);
    set_push(1'b1, 5'd3, 3'd2, 2'd1, 32'h2);
    step();
    chk("d2_group", sreg_req_group, 3);
    chk("d2_regnum", sreg_req_regnum, 2);
    chk("d2_plevel", sreg_req_plevel, 1);
    chk("d2_val", sreg_req_val, 32'h2);
    chk("d2_pending", sreg_pending, 1);
    set_push(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
    step();
    chk("d3_pending", sreg_pending, 0);
    chk("d3_valid", sreg_req_valid, 0);

    // Retire and counter wrap (CNT_WIDTH=4)
    for (int i = 0; i < 17; i++) begin
      insn.valid = 1'b1;
      insn.addr  = 30'h100 + 30'(i);
      step();
      chk("ret_valid", retire_valid, 1);
      chk("ret_addr", retire_addr, 30'h100 + 30'(i));
    end
    insn.valid = 1'b0;
    step();
    chk("ret_idle", retire_valid, 0);
    chk("ret_count_wrap", retired_count, 1);

    // Back-pressure and overflow
    sreg_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_push(1'b1, 5'(i), 3'(i), 2'(i), 32'h10 + 32'(i));
      step();
      chk("bp_stall", wb_stall, (i >= 2) ? 1 : 0);
      chk("bp_ovf", sq_overflow, (i == 4) ? 1 : 0);
      chk("bp_head", sreg_req_val, 32'h10);
    end
    set_push(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
    sreg_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain_valid", sreg_req_valid, 1);
      chk("bp_drain_val", sreg_req_val, 32'h10 + 32'(i));
      chk("bp_drain_grp", sreg_req_group, i);
      step();
    end
    chk("bp_empty", sreg_req_valid, 0);
    chk("bp_ovf_sticky", sq_overflow, 1);

    // Asynchronous reset with three entries queued
    sreg_req_ready = 1'b0;
    insn.valid = 1'b1; insn.addr = 30'h2A;
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, 5'd1, 3'd1, 2'd1, 32'h30 + 32'(i));
      step();
    end
    set_push(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
    insn.valid = 1'b0;
    chk("ar_pre_stall", wb_stall, 1);
    chk("ar_pre_pending", sreg_pending, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", sreg_req_valid, 0);
    chk("ar_pending", sreg_pending, 0);
    chk("ar_stall", wb_stall, 0);
    chk("ar_ovf", sq_overflow, 0);
    chk("ar_val", sreg_req_val, 0);
    chk("ar_waddr", rf_waddr, 0);
    chk("ar_wdata", rf_wdata, 0);
    chk("ar_ret_addr", retire_addr, 0);
    chk("ar_ret_count", retired_count, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_post_empty", sreg_req_valid, 0);

    // Full queue with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, 5'd2, 3'd3, 2'd2, 32'h20 + 32'(i));
      step();
    end
    chk("fs_full_stall", wb_stall, 1);
    sreg_req_ready = 1'b1;
    set_push(1'b1, 5'd2, 3'd3, 2'd2, 32'h24);
    step();
    chk("fs_no_ovf", sq_overflow, 0);
    chk("fs_stall", wb_stall, 1);
    chk("fs_head", sreg_req_val, 32'h21);
    sreg_req_ready = 1'b0;
    set_push(1'b1, 5'd2, 3'd3, 2'd2, 32'h25);
    step();
    chk("fs_drop_ovf", sq_overflow, 1);
    chk("fs_hold_head", sreg_req_val, 32'h21);
    set_push(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
    sreg_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fs_drain_val", sreg_req_val, 32'h21 + 32'(i));
      step();
    end
    chk("fs_empty", sreg_req_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/writeback.md
# writeback

Final pipeline stage, directly downstream of the execute stage. Registers execute's register-file write onto the RF write port and forward it for bypass. Buffers special-register (SREG) writes in a small FIFO drained over a valid/ready port, and raises back-pressure and pending flags to the front end. Retires instructions and keeps a retired-instruction counter.

## Interface
- REG_WIDTH, core::REG_WIDTH: data width of RF/SREG values.
- RF_ADDR_WIDTH, core::RF_ADDR_WIDTH: RF address width.
- SQ_DEPTH, 4: SREG write-queue entries; power of two, ≥2.
- CNT_WIDTH, 32: retired-instruction counter width.

- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- insn  in  core::InsnBundle  instruction leaving execute (valid, addr, insn).
- ex_rf_wr_en  in  1  execute RF write request.
- ex_rf_wr_addr  in  RF_ADDR_WIDTH  RF destination.
- ex_rf_wr_val  in  REG_WIDTH  RF data.
- ex_sreg_wr_en  in  1  execute SREG write request.
- ex_sreg_wr_group  in  5  SREG group.
- ex_sreg_wr_regnum  in  3  SREG number.
- ex_sreg_wr_plevel  in  2  privilege level.
- ex_sreg_wr_val  in  REG_WIDTH  SREG data.
- rf_we  out  1  RF write enable.
- rf_waddr  out  RF_ADDR_WIDTH  RF write address.
- rf_wdata  out  REG_WIDTH  RF write data; rf_we/rf_waddr/rf_wdata also serve as the bypass source.
- sreg_req_valid  out  1  queue head valid.
- sreg_req_ready  in  1  SREG file accepts head.
- sreg_req_group  out  5  head group.
- sreg_req_regnum  out  3  head number.
- sreg_req_plevel  out  2  head privilege level.
- sreg_req_val  out  REG_WIDTH  head data.
- sreg_pending  out  1  queue non-empty; front end interlocks SREG reads (MFS) on it.
- wb_stall  out  1  back-pressure: upstream must not issue new SREG writes.
- sq_overflow  out  1  sticky error: an SREG write was dropped.
- retire_valid  out  1  instruction retired this cycle.
- retire_addr  out  same as insn.addr  retired instruction word address.
- retired_count  out  CNT_WIDTH  total retired instructions.

## Operation
- Reset (rst_n low, asynchronous):
  - All outputs are 0.
  - Queue is empty; head and tail pointers are 0.
  - sq_overflow is cleared.
- RF path:
  - Each cycle, rf_we <= ex_rf_wr_en, rf_waddr <= ex_rf_wr_addr, rf_wdata <= ex_rf_wr_val.
  - rf_waddr and rf_wdata load only when ex_rf_wr_en=1; otherwise they hold.
- Retire:
  - retire_valid <= insn.valid; retire_addr <= insn.addr.
  - retired_count increments by 1 when insn.valid=1 and wraps modulo 2^CNT_WIDTH.
- SREG queue (circular, SQ_DEPTH entries; entry = {group, regnum, plevel, val}):
  - Push when ex_sreg_wr_en=1.
  - Pop when sreg_req_valid && sreg_req_ready.
  - Push is accepted when count<SQ_DEPTH, or when count==SQ_DEPTH and a pop happens in the same cycle.
  - Otherwise the push is dropped and sq_overflow sets; it clears only on reset.
  - Simultaneous push and pop on an empty queue: the pushed entry is enqueued; no same-cycle bypass to sreg_req_*.
  - Pointers wrap from SQ_DEPTH-1 to 0.
  - count ranges 0..SQ_DEPTH.
- Outputs from the queue:
  - sreg_req_* present the head entry combinationally from the storage array.
  - sreg_req_valid = (count!=0).
  - sreg_pending = (count!=0).
  - wb_stall = (count >= SQ_DEPTH-1). This leaves one free slot for the write already in flight from execute.
- Handshake: while sreg_req_valid=1 and sreg_req_ready=0, the head entry and sreg_req_* stay stable.
- No state machine beyond the queue; ordering of SREG writes is strictly FIFO.

## Timing
- RF write: 1-cycle latency, ex_rf_wr_en at edge N → rf_we at edge N+1.
- Retire: 1-cycle latency.
- SREG write sampled at edge N → sreg_req_valid from edge N (after update) if the queue was empty; earliest pop is at edge N+1.
- Counts and flags update at the edge following the event:
  - count, wb_stall and sreg_pending follow the push/pop.
  - sq_overflow sets at the edge of the dropped push.
- Throughput: one push and one pop per cycle, sustained.

## Test plan
- Reset mid-operation: 3 entries queued, count=3, assert rst_n=0 asynchronously → all outputs 0 immediately, without waiting for a clock edge; queue empty after release.
- RF path: ex_rf_wr_en=1, addr=5, val=0xDEAD_BEEF at cycle 0 → rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF at cycle 1; rf_we=0 at cycle 2.
- SREG drain order: push (10,7,0,0x1), (3,2,1,0x2), ready=1 → two handshakes, data 0x1 then 0x2; sreg_pending falls after the second pop.
- Back-pressure: ready=0, push 3 entries (SQ_DEPTH=4) → wb_stall=1 after the 3rd push; 4th push accepted, count=4; 5th push dropped, sq_overflow=1; ready=1 → 4 entries drain in order.
- Full plus simultaneous push/pop: count=4, push and pop in the same cycle → push accepted, count stays 4, no overflow.
- Retire and wrap: CNT_WIDTH=4, 17 valid instructions → retired_count=1; retire_addr matches each insn.addr one cycle later.
